// File: rtl/seg_scan_display_if.sv
// Bundle between the data-path registers and the scan driver: display content in,
// digit-select / segment pins and the frame strobe out.
interface seg_scan_display_if #(
   parameter int DIGITS = 8
);
   logic [4*DIGITS-1:0] data;
   logic                load;
   logic [DIGITS-1:0]   dp_en;
   logic [DIGITS-1:0]   sym_en;
   logic [DIGITS-1:0]   blank;
   logic                lz_en;
   logic [3:0]          bright;
   logic [DIGITS-1:0]   digit_sel;
   logic [7:0]          seg;
   logic                frame_tick;

   modport master (
      output data, load, dp_en, sym_en, blank, lz_en, bright,
      input  digit_sel, seg, frame_tick
   );

   modport slave (
      input  data, load, dp_en, sym_en, blank, lz_en, bright,
      output digit_sel, seg, frame_tick
   );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scan driver: slot prescaler, double-buffered content,
// leading-zero suppression and on-time brightness control.

// One digit's glyph, before polarity; seg[7]=dp, seg[6:0]=g..a.
module seg_scan_lane (
   input  logic [3:0] nib,
   input  logic       dp,
   input  logic       sym,
   input  logic       blank,
   input  logic       sup,
   output logic [7:0] glyph
);
   logic [6:0] hex;

   always_comb begin
      hex = 7'h00;
      unique case (nib)
         4'h0: hex = 7'h3F;
         4'h1: hex = 7'h06;
         4'h2: hex = 7'h5B;
         4'h3: hex = 7'h4F;
         4'h4: hex = 7'h66;
         4'h5: hex = 7'h6D;
         4'h6: hex = 7'h7D;
         4'h7: hex = 7'h07;
         4'h8: hex = 7'h7F;
         4'h9: hex = 7'h6F;
         4'hA: hex = 7'h77;
         4'hB: hex = 7'h7C;
         4'hC: hex = 7'h39;
         4'hD: hex = 7'h5E;
         4'hE: hex = 7'h79;
         4'hF: hex = 7'h71;
      endcase
   end

   always_comb begin
      if (blank)    glyph = 8'h00;
      else if (sym) glyph = {dp, 7'h40};
      else if (sup) glyph = {dp, 7'h00};
      else          glyph = {dp, hex};
   end
endmodule

module seg_scan_display #(
   parameter int DIGITS          = 8,
   parameter int CLK_DIV         = 50000,
   parameter int SEL_ACTIVE_HIGH = 1,
   parameter int SEG_ACTIVE_HIGH = 1
) (
   input logic               clk,
   input logic               rtsn,
   seg_scan_display_if.slave bus
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = $clog2(DIGITS);
   localparam int PW = CW + 6;

   localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{(SEL_ACTIVE_HIGH == 0)}};
   localparam logic [7:0]        SEG_OFF = {8{(SEG_ACTIVE_HIGH == 0)}};

   typedef struct packed {
      logic [DIGITS-1:0][3:0] data;
      logic [DIGITS-1:0]      dp;
      logic [DIGITS-1:0]      sym;
      logic [DIGITS-1:0]      blank;
   } buf_t;

   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;
   logic [3:0]             bright_s;
   buf_t                   pend, act;
   logic                   frame_tick_q;
   logic [DIGITS-1:0]      sel_q;
   logic [7:0]             seg_q;

   logic                   wrap, last, en;
   logic [PW-1:0]          on_prod, on_lim;
   logic [DIGITS-1:0]      sup, sel_oh;
   logic                   run;
   logic [DIGITS-1:0][7:0] glyphs;
   logic [7:0]             glyph_cur;

   assign wrap = (cnt == CW'(CLK_DIV - 1));
   assign last = (idx == IW'(DIGITS - 1));

   // bright_s refreshes at cnt=0, which is always dark, so a slot never mixes two levels.
   assign on_prod = (PW'(bright_s) + PW'(1)) * PW'(CLK_DIV);
   assign on_lim  = on_prod >> 4;
   assign en      = (cnt != '0) && (PW'(cnt) < on_lim);

   // Suppression runs from the most significant digit down; blanked digits keep it going.
   always_comb begin
      run = bus.lz_en;
      sup = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         run    = run & (act.blank[i] |
                         ((act.data[i] == 4'h0) & ~act.sym[i] & ~act.dp[i]));
         sup[i] = run;
      end
   end

   seg_scan_lane u_lane [DIGITS-1:0] (
      .nib   (act.data),
      .dp    (act.dp),
      .sym   (act.sym),
      .blank (act.blank),
      .sup   (sup),
      .glyph (glyphs)
   );

   assign glyph_cur = glyphs[idx];

   // Digit i sits on bit DIGITS-1-i of the select bus.
   always_comb begin
      sel_oh = '0;
      for (int i = 0; i < DIGITS; i++)
         sel_oh[DIGITS-1-i] = (idx == IW'(i));
   end

   always_ff @(posedge clk or negedge rtsn) begin
      if (!rtsn) begin
         cnt          <= '0;
         idx          <= '0;
         bright_s     <= '0;
         pend         <= '0;
         act          <= '0;
         frame_tick_q <= 1'b0;
         sel_q        <= SEL_OFF;
         seg_q        <= SEG_OFF;
      end else begin
         frame_tick_q <= wrap && last;
         if (wrap) begin
            cnt <= '0;
            idx <= last ? '0 : idx + 1'b1;
            if (last) act <= pend;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (bus.load)
            pend <= {bus.data, bus.dp_en, bus.sym_en, bus.blank};
         if (cnt == '0)
            bright_s <= bus.bright;
         sel_q <= en ? (sel_oh ^ SEL_OFF) : SEL_OFF;
         seg_q <= en ? (glyph_cur ^ SEG_OFF) : SEG_OFF;
      end
   end

   assign bus.digit_sel  = sel_q;
   assign bus.seg        = seg_q;
   assign bus.frame_tick = frame_tick_q;
endmodule
